binary2bcd_div_core: RTL and testbench
======================================

BINARY2BCD_DIV_CORE -- requirements
Module: binary2bcd_div

Interface
REQ-001 SHALL have parameter IN_W, default 14, meaning width of the binary input.
REQ-002 SHALL have parameter BCD_DIGITS, default 4, meaning the number of BCD digits produced; the output width SHALL be 4*BCD_DIGITS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_binary, input, IN_W bits: the unsigned binary value to convert.
REQ-006 SHALL have port start, input, 1 bit: a conversion request, sampled at a rising edge.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port valid, output, 1 bit: a one-cycle pulse marking that packed_bcd has just been updated.
REQ-009 SHALL have port packed_bcd, output, 4*BCD_DIGITS bits: packed BCD, ones digit in [3:0], tens in [7:4], hundreds in [11:8], thousands in [15:12].
REQ-010 SHALL have port ovf, output, 1 bit: range-error flag (see Configuration).

Function
REQ-011 SHALL, when idle and start=1 at edge N, capture in_binary into an internal working register and set busy.
- Conversion uses repeated divide-by-10: each step's remainder becomes the next digit, least significant first.
REQ-012 SHALL perform one divide-by-10 step per clock, at edges N+1 through N+BCD_DIGITS-1.
- After the last step, the remaining quotient is the most significant digit.
REQ-013 SHALL, at edge N+BCD_DIGITS-1, load packed_bcd, clear busy, and assert valid for exactly one cycle.
- Latency is 3 clocks with the default parameters.
REQ-014 SHALL hold packed_bcd stable between conversions.
REQ-015 SHALL ignore start while busy=1; the captured operand is unaffected by in_binary changes during a conversion.
REQ-016 SHALL accept a new start in the same cycle that valid is high (back-to-back conversions).
REQ-017 SHALL, for every input 0..9999, produce exactly the decimal digits of the input, e.g. 1234 gives 16'h1234.
REQ-018 SHALL keep every emitted ones, tens and hundreds digit within 0..9.

Reset
REQ-019 SHALL, while rst=1, immediately force packed_bcd=0, busy=0, valid=0, ovf=0, and the FSM to IDLE, independent of clk.
REQ-020 SHALL abort any conversion in progress on reset; no valid pulse follows the aborted conversion.
REQ-021 SHALL ignore start at any edge where rst=1.

Configuration
REQ-022 SHALL support macro B2BCD_RANGE_CHECK_EN.
- When defined: an input greater than 9999 yields packed_bcd=16'h9999, and ovf=1 is loaded together with valid at the same latency.
- When defined: ovf is cleared on the next in-range result.
REQ-023 SHALL, when B2BCD_RANGE_CHECK_EN is not defined, tie ovf to 0.
- For an input greater than 9999, the thousands digit is the low 4 bits of the final quotient; no saturation is applied.

Structure
REQ-024 SHALL take from the shared package b2bcd_pkg:
- the FSM state type (IDLE, DIV, DONE);
- the constant BCD_MAX=9999;
- the constant DIGIT_W=4.
REQ-025 SHALL place the divide-by-10 step in one combinational sub-module, div10.
- Input: IN_W-bit value.
- Outputs: quotient and 4-bit remainder.
- The sub-module is instantiated once and reused on every step.

Verification
REQ-026 SHALL verify: in_binary=0, start pulse -> valid 3 clocks later with packed_bcd=16'h0000, ovf=0.
REQ-027 SHALL verify: in_binary=9999 -> 16'h9999; in_binary=1234 -> 16'h1234; in_binary=10 -> 16'h0010.
REQ-028 SHALL verify: with the macro defined, in_binary=10000 -> 16'h9999 and ovf=1; a following conversion of 5 -> 16'h0005 with ovf=0.
REQ-029 SHALL verify: start=1 and a new in_binary applied while busy -> ignored; the result matches the first operand.
REQ-030 SHALL verify: rst asserted mid-conversion -> all outputs 0 immediately, no valid pulse, and the next start converts correctly.
REQ-031 SHALL verify: an exhaustive sweep of 0..9998 with back-to-back starts, each result matching a decimal reference model.

Source files
------------

// File: rtl/b2bcd_pkg.sv
// Shared definitions for the divide-by-10 binary-to-BCD converter:
// FSM state type, largest representable decimal value and digit width.
package b2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } b2bcd_state_e;

    // Largest value that fits in four BCD digits.
    localparam int BCD_MAX = 9999;

    // Bits per BCD digit.
    localparam int DIGIT_W = 4;

endpackage

// File: rtl/binary2bcd_div_core_div10.sv
// div10: single combinational divide-by-10 step. The converter feeds its
// working register through this block once per clock; the remainder is the
// next decimal digit and the quotient becomes the new working value.
module div10
    import b2bcd_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic [IN_W-1:0]    value,
    output logic [IN_W-1:0]    quot,
    output logic [DIGIT_W-1:0] rem
);

    localparam logic [IN_W-1:0] TEN = IN_W'(10);

    // Quotient and remainder of value / 10; the remainder always fits in a digit.
    always_comb begin
        quot = value / TEN;
        rem  = DIGIT_W'(value % TEN);
    end

endmodule

// File: rtl/binary2bcd_div_core.sv
// binary2bcd_div_core: multi-cycle binary to packed-BCD converter using
// repeated divide-by-10. One division step per clock; the final quotient is
// taken as the most significant digit, giving a start-to-valid latency of
// BCD_DIGITS-1 clocks.
// Optional build macro: B2BCD_RANGE_CHECK_EN -- saturates out-of-range
// inputs to all nines and raises ovf; without it ovf is tied low and the
// top digit is simply the low bits of the final quotient.
// BCD_DIGITS must be at least 3; IN_W must be at least DIGIT_W.
module binary2bcd_div_core
    import b2bcd_pkg::*;
#(
    parameter int IN_W       = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_W-1:0]         in_binary,
    input  logic                    start,
    output logic                    busy,
    output logic                    valid,
    output logic [4*BCD_DIGITS-1:0] packed_bcd,
    output logic                    ovf
);

    // Digits captured before the last step (the last remainder and the
    // final quotient go straight into the result word).
    localparam int NUM_LOW = BCD_DIGITS - 2;
    localparam int CNT_W   = (BCD_DIGITS > 2) ? $clog2(BCD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BCD_DIGITS - 2);

    b2bcd_state_e state_reg, state_next;

    logic [IN_W-1:0]              work_reg;
    logic [CNT_W-1:0]             step_cnt_reg;
    logic [NUM_LOW*DIGIT_W-1:0]   digits_reg;
    logic [4*BCD_DIGITS-1:0]      packed_bcd_reg;

    logic [IN_W-1:0]              quot;
    logic [DIGIT_W-1:0]           rem;
    logic [4*BCD_DIGITS-1:0]      result_word;
    logic [4*BCD_DIGITS-1:0]      final_word;

    logic                         capture;
    logic                         last_step;

    // One shared divider, always looking at the working register.
    div10 #(
        .IN_W (IN_W)
    ) u_div10 (
        .value (work_reg),
        .quot  (quot),
        .rem   (rem)
    );

    // A request is taken whenever no division is running; this includes the
    // DONE cycle so conversions can run back to back.
    assign capture   = start && (state_reg != DIV);
    assign last_step = (state_reg == DIV) && (step_cnt_reg == LAST_STEP);

    // Final step: quotient low bits on top, fresh remainder below, then the
    // digits collected on earlier steps.
    assign result_word = {quot[DIGIT_W-1:0], rem, digits_reg};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? DIV : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture the operand, step the division, collect digits and
    // publish the result on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_reg       <= '0;
            step_cnt_reg   <= '0;
            digits_reg     <= '0;
            packed_bcd_reg <= '0;
        end else begin
            if (capture) begin
                work_reg     <= in_binary;
                step_cnt_reg <= '0;
            end else if (state_reg == DIV) begin
                work_reg     <= quot;
                step_cnt_reg <= step_cnt_reg + 1'b1;
                for (int i = 0; i < NUM_LOW; i++) begin
                    if (step_cnt_reg == CNT_W'(i)) begin
                        digits_reg[i*DIGIT_W +: DIGIT_W] <= rem;
                    end
                end
            end
            if (last_step) begin
                packed_bcd_reg <= final_word;
            end
        end
    end

`ifdef B2BCD_RANGE_CHECK_EN
    localparam logic [IN_W-1:0] MAX_IN = IN_W'(BCD_MAX);

    logic range_err_reg;
    logic ovf_reg;

    // Flag an out-of-range operand at capture; expose it with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            if (capture) begin
                range_err_reg <= (in_binary > MAX_IN);
            end
            if (last_step) begin
                ovf_reg <= range_err_reg;
            end
        end
    end

    assign final_word = range_err_reg ? {BCD_DIGITS{4'h9}} : result_word;
    assign ovf        = ovf_reg;
`else
    assign final_word = result_word;
    assign ovf        = 1'b0;
`endif

    assign busy       = (state_reg == DIV);
    assign valid      = (state_reg == DONE);
    assign packed_bcd = packed_bcd_reg;

endmodule

// File: tb/tb_binary2bcd_div_core.sv
// Scoreboard bench for binary2bcd_div_core: the driver pushes the expected
// result and expected completion cycle for each accepted request; a monitor
// pops and compares on every valid pulse.
module tb_binary2bcd_div_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] in_binary;
    logic        start;
    logic        busy;
    logic        valid;
    logic [15:0] packed_bcd;
    logic        ovf;

    typedef struct packed {
        logic [13:0] din;
        logic [15:0] bcd;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    binary2bcd_div_core #(
        .IN_W       (14),
        .BCD_DIGITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_binary  (in_binary),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .packed_bcd (packed_bcd),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digits by plain arithmetic on the integer value.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    // Present a request for one edge and record what must come back 3 edges later.
    task automatic issue(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        in_binary = v;
        start     = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back('{din: v, bcd: exp_bcd, ovf: exp_ovf, cyc: 32'(cycle + 3)});
        start = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: packed_bcd=%h ovf=%b with nothing outstanding", packed_bcd, ovf);
            end else begin
                mon_e = sb_q.pop_front();
                $display("conv in=%0d bcd=%h ovf=%b cyc=%0d", mon_e.din, packed_bcd, ovf, cycle);
                check("bcd", 32'(packed_bcd), 32'(mon_e.bcd));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("latency", 32'(cycle), mon_e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_binary = '0;
        #12;
        check("reset_bcd",   32'(packed_bcd), 32'h0);
        check("reset_busy",  32'(busy),       32'h0);
        check("reset_valid", 32'(valid),      32'h0);
        check("reset_ovf",   32'(ovf),        32'h0);
        // start held high during reset must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("reset_start_ignored", 32'(busy), 32'h0);

        // Directed vectors, isolated
        issue(14'd0,    16'h0000, 1'b0); repeat (5) @(posedge clk); #1;
        issue(14'd9999, 16'h9999, 1'b0); repeat (5) @(posedge clk); #1;
        issue(14'd1234, 16'h1234, 1'b0); repeat (5) @(posedge clk); #1;
        issue(14'd10,   16'h0010, 1'b0); repeat (5) @(posedge clk); #1;
`ifdef B2BCD_RANGE_CHECK_EN
        issue(14'd10000, 16'h9999, 1'b1); repeat (5) @(posedge clk); #1;
        issue(14'd5,     16'h0005, 1'b0); repeat (5) @(posedge clk); #1;
        issue(14'd16383, 16'h9999, 1'b1); repeat (5) @(posedge clk); #1;
        issue(14'd5,     16'h0005, 1'b0); repeat (5) @(posedge clk); #1;
`else
        // 10000 -> remainders 0,0,0, final quotient 10 -> top nibble 4'hA
        issue(14'd10000, 16'hA000, 1'b0); repeat (5) @(posedge clk); #1;
        issue(14'd5,     16'h0005, 1'b0); repeat (5) @(posedge clk); #1;
        // 16383 -> remainders 3,8,3, final quotient 16 -> top nibble 4'h0
        issue(14'd16383, 16'h0383, 1'b0); repeat (5) @(posedge clk); #1;
`endif

        // Start and a new operand while busy must be ignored
        issue(14'd1234, 16'h1234, 1'b0);
        in_binary = 14'd4321;
        start     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("busy_mid_conversion", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Reset mid-conversion: outputs clear at once, no valid follows
        issue(14'd777, 16'h0777, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_bcd",   32'(packed_bcd), 32'h0);
        check("abort_busy",  32'(busy),       32'h0);
        check("abort_valid", 32'(valid),      32'h0);
        check("abort_ovf",   32'(ovf),        32'h0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk); #1;
        issue(14'd42, 16'h0042, 1'b0); repeat (5) @(posedge clk); #1;

        // Back-to-back sweep: next start lands in the valid cycle
        for (int v = 0; v <= 9998; v++) begin
            issue(14'(v), ref_bcd(v), 1'b0);
            repeat (3) @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk); #1;

        // Drain: every expected result must have been seen
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
